// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and defaults for the single-cycle MIPS run
//                controller (run states, run status codes, default halt PC).
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Run controller states, 2-bit encoded.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } run_state_t;

  // Terminal status of a run.
  typedef enum logic [1:0] {
    STATUS_NONE    = 2'd0,
    STATUS_HALT    = 2'd1,
    STATUS_LOOP    = 2'd2,
    STATUS_TIMEOUT = 2'd3
  } run_status_t;

  // PC value that marks the normal end of a program.
  localparam logic [31:0] DEFAULT_HALT_ADDR = 32'h0000_00FC;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Width-parametrised up-counter that sticks at all-ones.
//                Clear has priority over enable.
//  Ports       : clk_i    - clock, rising edge
//                rst_i    - asynchronous active-high reset (count -> 0)
//                clr_i    - synchronous clear
//                en_i     - count enable
//                count_o  - registered count value
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/mips_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_run_ctrl
//  Description : Run controller for the single-cycle MIPS core. Sequences the
//                core reset after start, counts run cycles and retired
//                instructions, and ends the run on halt PC, self-loop or
//                timeout. All outputs are registered.
//  Ports       : clk_i          - clock, rising edge
//                rst_i          - asynchronous active-high reset
//                start_i        - run request, sampled in IDLE and DONE
//                pc_i           - core program counter
//                pc_valid_i     - pc_i is a retired instruction this cycle
//                core_rst_o     - reset to the MIPS core
//                running_o      - high while in RUN
//                done_o         - high while in DONE
//                status_o       - 0 none, 1 halt, 2 self-loop, 3 timeout
//                cycle_count_o  - cycles spent in RUN (saturating)
//                instr_count_o  - RUN cycles with pc_valid_i (saturating)
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_run_ctrl
  import mips_pkg::*;
#(
  parameter int                 ADDR_W      = 32,
  parameter int                 RST_CYCLES  = 4,
  parameter int                 TIMEOUT     = 1000,
  parameter logic [ADDR_W-1:0]  HALT_ADDR   = ADDR_W'(DEFAULT_HALT_ADDR),
  parameter int                 STALL_LIMIT = 8,
  parameter int                 CNT_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  output logic              core_rst_o,
  output logic              running_o,
  output logic              done_o,
  output logic [1:0]        status_o,
  output logic [CNT_W-1:0]  cycle_count_o,
  output logic [CNT_W-1:0]  instr_count_o
);

  // Reset-cycle down-counter only has to hold RST_CYCLES-1.
  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  // Stall counter must be able to hold STALL_LIMIT.
  localparam int SC_W = $clog2(STALL_LIMIT + 1);

  localparam logic [RC_W-1:0]  RST_LOAD_C    = RC_W'(RST_CYCLES - 1);
  localparam logic [SC_W:0]    STALL_LIM_C   = (SC_W + 1)'(STALL_LIMIT);
  localparam logic [CNT_W:0]   TIMEOUT_C     = (CNT_W + 1)'(TIMEOUT);

  run_state_t        state_q,     state_d;
  run_status_t       status_q,    status_d;
  logic              core_rst_q,  core_rst_d;
  logic              running_q,   running_d;
  logic              done_q,      done_d;
  logic [RC_W-1:0]   rst_cnt_q,   rst_cnt_d;
  logic [SC_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [ADDR_W-1:0] last_pc_q,   last_pc_d;

  logic              cnt_clr;
  logic              cyc_en;
  logic              ins_en;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  instr_count;

  logic              same_pc;
  logic              hit_halt;
  logic              hit_loop;
  logic              hit_timeout;

  // Exit conditions evaluated on the current RUN cycle; the counters have not
  // yet absorbed this cycle, hence the +1 comparisons.
  assign same_pc     = pc_valid_i && (pc_i == last_pc_q);
  assign hit_halt    = pc_valid_i && (pc_i == HALT_ADDR);
  assign hit_loop    = same_pc &&
                       (({1'b0, stall_cnt_q} + (SC_W + 1)'(1)) >= STALL_LIM_C);
  assign hit_timeout = ({1'b0, cycle_count} + (CNT_W + 1)'(1)) == TIMEOUT_C;

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    rst_cnt_d   = rst_cnt_q;
    stall_cnt_d = stall_cnt_q;
    last_pc_d   = last_pc_q;
    cnt_clr     = 1'b0;
    cyc_en      = 1'b0;
    ins_en      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d   = ST_RESET;
          status_d  = STATUS_NONE;
          cnt_clr   = 1'b1;
          rst_cnt_d = RST_LOAD_C;
        end
      end

      ST_RESET: begin
        if (rst_cnt_q == '0) begin
          state_d     = ST_RUN;
          stall_cnt_d = '0;
          // All-ones guarantees the first retired PC never matches.
          last_pc_d   = {ADDR_W{1'b1}};
        end else begin
          rst_cnt_d = rst_cnt_q - RC_W'(1);
        end
      end

      ST_RUN: begin
        cyc_en = 1'b1;
        ins_en = pc_valid_i;

        if (pc_valid_i) begin
          if (same_pc) begin
            if (stall_cnt_q != {SC_W{1'b1}}) begin
              stall_cnt_d = stall_cnt_q + SC_W'(1);
            end
          end else begin
            stall_cnt_d = SC_W'(1);
          end
          last_pc_d = pc_i;
        end

        if (hit_halt) begin
          state_d  = ST_DONE;
          status_d = STATUS_HALT;
        end else if (hit_loop) begin
          state_d  = ST_DONE;
          status_d = STATUS_LOOP;
        end else if (hit_timeout) begin
          state_d  = ST_DONE;
          status_d = STATUS_TIMEOUT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they change on the
    // same edge as the state itself.
    core_rst_d = (state_d != ST_RUN);
    running_d  = (state_d == ST_RUN);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      status_q    <= STATUS_NONE;
      core_rst_q  <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      rst_cnt_q   <= '0;
      stall_cnt_q <= '0;
      last_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      core_rst_q  <= core_rst_d;
      running_q   <= running_d;
      done_q      <= done_d;
      rst_cnt_q   <= rst_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      last_pc_q   <= last_pc_d;
    end
  end

  sat_counter #(
    .WIDTH   (CNT_W)
  ) u_cycle_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (cnt_clr),
    .en_i    (cyc_en),
    .count_o (cycle_count)
  );

  sat_counter #(
    .WIDTH   (CNT_W)
  ) u_instr_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (cnt_clr),
    .en_i    (ins_en),
    .count_o (instr_count)
  );

  assign core_rst_o    = core_rst_q;
  assign running_o     = running_q;
  assign done_o        = done_q;
  assign status_o      = status_q;
  assign cycle_count_o = cycle_count;
  assign instr_count_o = instr_count;

endmodule : mips_run_ctrl
`default_nettype wire

// File: tb/tb_mips_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_run_ctrl
//  Description : Directed self-checking bench for mips_run_ctrl with
//                RST_CYCLES=4, TIMEOUT=1000, HALT_ADDR=0xFC, STALL_LIMIT=8.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pc = '0;
  logic        pc_valid = 1'b0;
  logic        core_rst;
  logic        running;
  logic        done;
  logic [1:0]  status;
  logic [31:0] cycle_count;
  logic [31:0] instr_count;

  int checks   = 0;
  int failures = 0;

  always #10 clk = !clk;

  mips_run_ctrl #(
    .ADDR_W      (32),
    .RST_CYCLES  (4),
    .TIMEOUT     (1000),
    .HALT_ADDR   (32'h0000_00FC),
    .STALL_LIMIT (8),
    .CNT_W       (32)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .pc_i          (pc),
    .pc_valid_i    (pc_valid),
    .core_rst_o    (core_rst),
    .running_o     (running),
    .done_o        (done),
    .status_o      (status),
    .cycle_count_o (cycle_count),
    .instr_count_o (instr_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge, then expect core_rst high for exactly 4 edges
  // (the start edge plus three more) and RUN from the 4th edge after start.
  task automatic start_seq(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_rst_e0"},    core_rst,    1);
    chk({tag, "_done_e0"},   done,        0);
    chk({tag, "_status_e0"}, status,      0);
    chk({tag, "_cyc_e0"},    cycle_count, 0);
    chk({tag, "_ins_e0"},    instr_count, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk({tag, "_rst_hold"}, core_rst, 1);
      chk({tag, "_run_low"},  running,  0);
    end
    tick();
    chk({tag, "_rst_fall"}, core_rst, 0);
    chk({tag, "_run_high"}, running,  1);
  endtask

  // PC walks 0,4,...,0xFC with pc_valid every cycle; halts on the 64th.
  task automatic halt_run(input string tag);
    for (int k = 0; k < 64; k++) begin
      pc       = 32'(k * 4);
      pc_valid = 1'b1;
      tick();
      if (k == 62) begin
        chk({tag, "_done_early"}, done, 0);
      end
    end
    pc_valid = 1'b0;
    chk({tag, "_done"},     done,        1);
    chk({tag, "_running"},  running,     0);
    chk({tag, "_core_rst"}, core_rst,    1);
    chk({tag, "_status"},   status,      1);
    chk({tag, "_cyc"},      cycle_count, 64);
    chk({tag, "_ins"},      instr_count, 64);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_core_rst", core_rst,    1);
    chk("rst_running",  running,     0);
    chk("rst_done",     done,        0);
    chk("rst_status",   status,      0);
    chk("rst_cyc",      cycle_count, 0);
    chk("rst_ins",      instr_count, 0);
    rst = 1'b0;
    tick();
    chk("idle_core_rst", core_rst, 1);

    // Reset sequencing and halt address
    start_seq("seq1");
    halt_run("halt1");

    // DONE holds counts and status while start is low
    pc       = 32'h0000_0040;
    pc_valid = 1'b1;
    tick();
    tick();
    pc_valid = 1'b0;
    chk("hold_done",   done,        1);
    chk("hold_status", status,      1);
    chk("hold_cyc",    cycle_count, 64);
    chk("hold_ins",    instr_count, 64);

    // Restart from DONE reproduces the same run
    start_seq("restart");
    halt_run("halt2");

    // Self-loop: 0,4,8 then 8 held; start asserted mid-run must be ignored
    start_seq("seq_loop");
    for (int k = 0; k < 10; k++) begin
      pc       = (k < 2) ? 32'(k * 4) : 32'h8;
      pc_valid = 1'b1;
      start    = (k == 4);
      tick();
      if (k == 8) begin
        chk("loop_done_early", done, 0);
      end
    end
    pc_valid = 1'b0;
    start    = 1'b0;
    chk("loop_done",   done,        1);
    chk("loop_status", status,      2);
    chk("loop_cyc",    cycle_count, 10);
    chk("loop_ins",    instr_count, 10);

    // Timeout with no retired instructions
    start_seq("seq_to");
    pc       = 32'h0000_00FC;
    pc_valid = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (k == 998) begin
        chk("to_done_early", done, 0);
      end
    end
    chk("to_done",   done,        1);
    chk("to_status", status,      3);
    chk("to_cyc",    cycle_count, 1000);
    chk("to_ins",    instr_count, 0);

    // Halt takes precedence over timeout on cycle 1000
    start_seq("seq_prec");
    for (int k = 0; k < 1000; k++) begin
      pc       = 32'h0000_00FC;
      pc_valid = (k == 999);
      tick();
    end
    pc_valid = 1'b0;
    chk("prec_done",   done,        1);
    chk("prec_status", status,      1);
    chk("prec_cyc",    cycle_count, 1000);
    chk("prec_ins",    instr_count, 1);

    // Mid-run asynchronous reset during run cycle 37
    start_seq("seq_mid");
    for (int k = 0; k < 36; k++) begin
      pc       = 32'(k * 4);
      pc_valid = 1'b1;
      tick();
    end
    chk("mid_cyc_before", cycle_count, 36);
    pc = 32'(36 * 4);
    #5;
    rst = 1'b1;
    #1;
    chk("mid_core_rst", core_rst,    1);
    chk("mid_running",  running,     0);
    chk("mid_done",     done,        0);
    chk("mid_status",   status,      0);
    chk("mid_cyc",      cycle_count, 0);
    chk("mid_ins",      instr_count, 0);
    tick();
    rst      = 1'b0;
    pc_valid = 1'b0;
    tick();
    chk("mid_idle_core_rst", core_rst, 1);
    chk("mid_idle_running",  running,  0);
    start_seq("seq_after_mid");
    halt_run("halt3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mips_run_ctrl
`default_nettype wire

// File: doc/mips_run_ctrl.md
# mips_run_ctrl

Parametrised run controller for the single-cycle MIPS core. It sequences the core's reset, counts executed cycles and retired instructions, and ends a run on halt address, self-loop stall, or timeout. It sits between the top-level clock/reset and the `MIPS` core, so the bench and board top both reduce to "drive `start`, wait for `done`." Unlike the bare clock-only bench stimulus, it gives each run bounded length, a terminal status, and statistics.

## Interface
- `ADDR_W`, 32: PC width.
- `RST_CYCLES`, 4: cycles `core_rst` is held high after `start`, minimum 1.
- `TIMEOUT`, 1000: maximum run cycles before forced stop, minimum 1.
- `HALT_ADDR`, 32'h0000_00FC: PC value that signals normal program end.
- `STALL_LIMIT`, 8: consecutive valid cycles with unchanged PC treated as a self-loop halt, minimum 2.
- `CNT_W`, 32: width of the statistics counters.

- `clk`  in  1  Single clock; all state changes on the rising edge.
- `rst`  in  1  Asynchronous, active-high reset.
- `start`  in  1  Pulse or level; sampled only in IDLE and DONE.
- `pc`  in  ADDR_W  Core program counter.
- `pc_valid`  in  1  `pc` holds a retired instruction's address this cycle.
- `core_rst`  out  1  Reset to the MIPS core.
- `running`  out  1  High in RUN.
- `done`  out  1  High in DONE.
- `status`  out  2  Run result: 0 none, 1 halt address, 2 self-loop, 3 timeout.
- `cycle_count`  out  CNT_W  Cycles spent in RUN.
- `instr_count`  out  CNT_W  Cycles in RUN with `pc_valid`=1.

## Operation
- States: IDLE, RESET, RUN, DONE. These are encoded as a 2-bit enum.
- Reset values:
  - State is IDLE.
  - `core_rst`=1. The core is held in reset while the controller is idle.
  - `running`=0, `done`=0, `status`=0.
  - Both counters are 0.
  - `rst_cnt`=0, `stall_cnt`=0, `last_pc`=0.
- IDLE:
  - `core_rst`=1.
  - On `start`, go to RESET, clear both counters and `status`, and load `rst_cnt`=RST_CYCLES-1.
- RESET:
  - `core_rst`=1.
  - Decrement `rst_cnt` each cycle.
  - When `rst_cnt`==0, go to RUN, clear `stall_cnt`, and set `last_pc` to all-ones so the first PC never counts as a stall.
- RUN:
  - `core_rst`=0.
  - `cycle_count` increments every cycle. `instr_count` increments when `pc_valid`.
  - When `pc_valid`, update `stall_cnt`: if `pc`==`last_pc`, increment it; otherwise reset it to 1. Then `last_pc`←`pc`.
  - When `pc_valid` is low, hold `stall_cnt` and `last_pc`.
- RUN exit checks, evaluated on the current cycle. Apply the first match in this priority order:
  1. `pc_valid` && `pc`==HALT_ADDR → `status`=1.
  2. `pc_valid` && `pc`==`last_pc` && `stall_cnt`+1 ≥ STALL_LIMIT → `status`=2.
  3. `cycle_count`+1 == TIMEOUT → `status`=3.
- On any exit, go to DONE. The exiting cycle is included in the counts.
- DONE:
  - `core_rst`=1, `done`=1.
  - Counters and `status` hold.
  - `start` re-enters RESET and clears them.
- `start` is ignored in RESET and RUN.
- Counters saturate at all-ones and never wrap.
- Reset mid-run: asynchronous return to IDLE with all reset values. `core_rst` asserts immediately, with no clock required.

## Timing
- `start` is high at edge N → RESET from N.
- `core_rst` falls at edge N+RST_CYCLES → first RUN cycle.
- Exit condition true during the cycle before edge M → DONE, with `done`=1 and `core_rst`=1 from edge M.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Maximum `cycle_count` at DONE equals TIMEOUT.

## Structure
- Shared package `mips_pkg`:
  - `run_state_t` enum.
  - `run_status_t` codes NONE/HALT/LOOP/TIMEOUT.
  - Default `HALT_ADDR`.
- No sub-module is needed except `sat_counter` (width-parametrised saturating counter with clear/enable), instantiated twice.
- The top bench replaces free-running clock-only stimulus with `mips_run_ctrl` driving `MIPS` reset. The clock remains `always #10 clk = !clk`.

## Test plan
All scenarios use RST_CYCLES=4, TIMEOUT=1000, HALT_ADDR=0xFC, STALL_LIMIT=8.
- **Reset sequencing:** apply `rst`, then `start` for 1 cycle. Required: `core_rst` high for exactly 4 edges, then `running`=1.
- **Halt address:** `pc_valid`=1 every cycle, `pc` counts 0,4,…,0xFC. Required: DONE, `status`=1, `cycle_count`=64, `instr_count`=64.
- **Self-loop:** `pc` goes 0,4,8, then 8 held. Required: DONE after the 8th consecutive 8, `status`=2, `cycle_count`=10.
- **Timeout:** `pc_valid`=0 always. Required: DONE at `cycle_count`=1000, `status`=3, `instr_count`=0. Halt precedence: with `pc`=0xFC on cycle 1000, required `status`=1.
- **Mid-run reset:** assert `rst` asynchronously at run cycle 37, between edges. Required: `core_rst`=1 before the next edge, state IDLE, counters 0, and `start` re-run behaves as the reset-sequencing scenario.
- **Restart from DONE:** after a halt, `start` again. Required: counters and `status` cleared at entry to RESET, and the second run reproduces identical counts.
